// File: rtl/hyst_window_trigger.sv
// Per-channel self-trigger: per-sample threshold compare (stage 1) feeding a
// windowing FSM with post-extension, retrigger, length cap and holdoff (stage 2).
module hyst_window_trigger #(
   parameter int unsigned S_AXIS_TDATA_WIDTH   = 128,
   parameter int unsigned ADC_RESOLUTION_WIDTH = 12,
   parameter int unsigned TIME_STAMP_WIDTH     = 16,
   parameter int unsigned LEN_WIDTH            = 8,
   parameter int unsigned TRG_CNT_WIDTH        = 16
) (
   input  logic                                   AXIS_ACLK,
   input  logic                                   AXIS_ARESETN,
   input  logic                                   ENABLE,
   input  logic                                   POLARITY,
   input  logic signed [ADC_RESOLUTION_WIDTH-1:0] BASELINE,
   input  logic signed [ADC_RESOLUTION_WIDTH:0]   THRESH_HI,
   input  logic signed [ADC_RESOLUTION_WIDTH:0]   THRESH_LO,
   input  logic [LEN_WIDTH-1:0]                   ACQUI_LEN,
   input  logic [LEN_WIDTH-1:0]                   POST_ACQUI_LEN,
   input  logic [TIME_STAMP_WIDTH-1:0]            CURRENT_TIME,
   input  logic [S_AXIS_TDATA_WIDTH-1:0]          S_AXIS_TDATA,
   output logic                                   O_TRIGGERED_FLAG,
   output logic [TIME_STAMP_WIDTH-1:0]            O_TIME_STAMP,
   output logic [((S_AXIS_TDATA_WIDTH/16) > 1 ? $clog2(S_AXIS_TDATA_WIDTH/16) : 1)-1:0] O_FIRST_IDX,
   output logic                                   O_OVER_LEN,
   output logic [TRG_CNT_WIDTH-1:0]               O_TRG_COUNT
);

   localparam int unsigned SPT   = S_AXIS_TDATA_WIDTH / 16;
   localparam int unsigned IDX_W = (SPT > 1) ? $clog2(SPT) : 1;
   localparam int unsigned AMP_W = ADC_RESOLUTION_WIDTH + 1;

   typedef enum logic [2:0] {IDLE, ARMED, ACTIVE, POST, HOLDOFF} state_t;

   // Low nibble of each 16-bit lane carries no sample information.
   logic unused_tdata;
   assign unused_tdata = ^S_AXIS_TDATA;

   logic signed [ADC_RESOLUTION_WIDTH-1:0] smp;
   logic signed [AMP_W-1:0]                smp_x, bl_x, amp;
   logic                                   hi_d, hi_q, lo_d, lo_q;
   logic [IDX_W-1:0]                       idx_d, idx_q;
   logic [TIME_STAMP_WIDTH-1:0]            time_q;

   // Stage 1: polarity-corrected amplitude per sample, reduced to hi/lo/first index.
   always_comb begin
      hi_d  = 1'b0;
      lo_d  = 1'b1;
      idx_d = '0;
      smp   = '0;
      smp_x = '0;
      bl_x  = {BASELINE[ADC_RESOLUTION_WIDTH-1], BASELINE};
      amp   = '0;
      for (int i = int'(SPT) - 1; i >= 0; i--) begin
         smp   = S_AXIS_TDATA[16*i+15 -: ADC_RESOLUTION_WIDTH];
         smp_x = {smp[ADC_RESOLUTION_WIDTH-1], smp};
         amp   = POLARITY ? (bl_x - smp_x) : (smp_x - bl_x);
         if (amp >= THRESH_HI) begin
            hi_d  = 1'b1;
            idx_d = IDX_W'(i);
         end
         if (!(amp < THRESH_LO)) lo_d = 1'b0;
      end
   end

   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         hi_q   <= 1'b0;
         lo_q   <= 1'b0;
         idx_q  <= '0;
         time_q <= '0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         idx_q  <= idx_d;
         time_q <= CURRENT_TIME;
      end
   end

   state_t                      state_d, state_q;
   logic [LEN_WIDTH-1:0]        len_cnt_d, len_cnt_q, post_cnt_d, post_cnt_q;
   logic [LEN_WIDTH-1:0]        acq_len_d, acq_len_q, post_len_d, post_len_q;
   logic [TIME_STAMP_WIDTH-1:0] ts_d, ts_q;
   logic [IDX_W-1:0]            fidx_d, fidx_q;
   logic [TRG_CNT_WIDTH-1:0]    cnt_d, cnt_q;
   logic                        flag_d, flag_q, over_d, over_q, cap_hit;

   // Stage 2: window FSM. ENABLE low overrides everything; cap beats retrigger beats expiry.
   always_comb begin
      state_d    = state_q;
      len_cnt_d  = len_cnt_q;
      post_cnt_d = post_cnt_q;
      acq_len_d  = acq_len_q;
      post_len_d = post_len_q;
      ts_d       = ts_q;
      fidx_d     = fidx_q;
      cnt_d      = cnt_q;
      over_d     = 1'b0;
      cap_hit    = (acq_len_q != '0) && (len_cnt_q == acq_len_q);
      if (!ENABLE) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:  state_d = ARMED;
            ARMED: begin
               if (hi_q) begin
                  state_d    = ACTIVE;
                  ts_d       = time_q;
                  fidx_d     = idx_q;
                  acq_len_d  = ACQUI_LEN;
                  post_len_d = POST_ACQUI_LEN;
                  len_cnt_d  = LEN_WIDTH'(1);
                  post_cnt_d = '0;
                  if (cnt_q != '1) cnt_d = cnt_q + TRG_CNT_WIDTH'(1);
               end
            end
            ACTIVE: begin
               len_cnt_d = len_cnt_q + LEN_WIDTH'(1);
               if (cap_hit) begin
                  state_d = HOLDOFF;
                  over_d  = 1'b1;
               end else if (lo_q && !hi_q) begin
                  state_d    = (post_len_q == '0) ? ARMED : POST;
                  post_cnt_d = '0;
               end
            end
            POST: begin
               len_cnt_d = len_cnt_q + LEN_WIDTH'(1);
               if (cap_hit) begin
                  state_d = HOLDOFF;
                  over_d  = 1'b1;
               end else if (hi_q) begin
                  state_d = ACTIVE;
               end else if (post_cnt_q == post_len_q - LEN_WIDTH'(1)) begin
                  state_d = ARMED;
               end else begin
                  post_cnt_d = post_cnt_q + LEN_WIDTH'(1);
               end
            end
            HOLDOFF: if (lo_q) state_d = ARMED;
            default: state_d = IDLE;
         endcase
      end
      flag_d = (state_d == ACTIVE) || (state_d == POST);
   end

   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         state_q    <= IDLE;
         len_cnt_q  <= '0;
         post_cnt_q <= '0;
         acq_len_q  <= '0;
         post_len_q <= '0;
         ts_q       <= '0;
         fidx_q     <= '0;
         cnt_q      <= '0;
         flag_q     <= 1'b0;
         over_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_cnt_q  <= len_cnt_d;
         post_cnt_q <= post_cnt_d;
         acq_len_q  <= acq_len_d;
         post_len_q <= post_len_d;
         ts_q       <= ts_d;
         fidx_q     <= fidx_d;
         cnt_q      <= cnt_d;
         flag_q     <= flag_d;
         over_q     <= over_d;
      end
   end

   assign O_TRIGGERED_FLAG = flag_q;
   assign O_TIME_STAMP     = ts_q;
   assign O_FIRST_IDX      = fidx_q;
   assign O_OVER_LEN       = over_q;
   assign O_TRG_COUNT      = cnt_q;

endmodule

// File: tb/tb_hyst_window_trigger.sv
// Directed bench for hyst_window_trigger; a second instance with a 4-bit
// trigger counter exercises counter saturation in few cycles.
module tb_hyst_window_trigger;

   logic               clk, rst_n, ena, pol;
   logic signed [11:0] bl;
   logic signed [12:0] thi, tlo;
   logic [7:0]         alen, plen;
   logic [15:0]        cur_time;
   logic [127:0]       tdata;

   logic               flag, over, s_flag, s_over;
   logic [15:0]        ts, s_ts, cnt;
   logic [2:0]         fidx, s_fidx;
   logic [3:0]         s_cnt;

   int                 vectors = 0;
   int                 errors  = 0;
   int                 hi_cnt, over_cnt, rises;
   logic               prev_flag;
   logic [15:0]        ct_v;

   hyst_window_trigger dut (
      .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n), .ENABLE(ena), .POLARITY(pol),
      .BASELINE(bl), .THRESH_HI(thi), .THRESH_LO(tlo), .ACQUI_LEN(alen),
      .POST_ACQUI_LEN(plen), .CURRENT_TIME(cur_time), .S_AXIS_TDATA(tdata),
      .O_TRIGGERED_FLAG(flag), .O_TIME_STAMP(ts), .O_FIRST_IDX(fidx),
      .O_OVER_LEN(over), .O_TRG_COUNT(cnt)
   );

   hyst_window_trigger #(.TRG_CNT_WIDTH(4)) dut_sat (
      .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n), .ENABLE(ena), .POLARITY(pol),
      .BASELINE(bl), .THRESH_HI(thi), .THRESH_LO(tlo), .ACQUI_LEN(alen),
      .POST_ACQUI_LEN(plen), .CURRENT_TIME(cur_time), .S_AXIS_TDATA(tdata),
      .O_TRIGGERED_FLAG(s_flag), .O_TIME_STAMP(s_ts), .O_FIRST_IDX(s_fidx),
      .O_OVER_LEN(s_over), .O_TRG_COUNT(s_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [127:0] all_s(input int s);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[16*i +: 16] = {12'(s), 4'b0000};
      return r;
   endfunction

   function automatic logic [127:0] set_lane(input logic [127:0] b, input int i, input int s);
      logic [127:0] r;
      r = b;
      r[16*i +: 16] = {12'(s), 4'b0000};
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one beat, advance to the next falling edge, accumulate flag statistics.
   task automatic step(input logic [127:0] d);
      tdata    = d;
      cur_time = ct_v;
      ct_v     = ct_v + 16'd1;
      @(negedge clk);
      if (flag) hi_cnt++;
      if (flag && !prev_flag) rises++;
      if (over) over_cnt++;
      prev_flag = flag;
   endtask

   task automatic clr();
      hi_cnt    = 0;
      over_cnt  = 0;
      rises     = 0;
      prev_flag = flag;
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b1; pol = 1'b0; bl = '0;
      thi = 13'sd400; tlo = 13'sd200; alen = 8'd0; plen = 8'd4;
      ct_v = 16'd0; cur_time = '0; tdata = '0;
      clr();
      step(all_s(0));
      step(all_s(0));
      chk("rst_flag", 32'(flag), 32'd0);
      chk("rst_ts",   32'(ts),   32'd0);
      chk("rst_idx",  32'(fidx), 32'd0);
      chk("rst_over", 32'(over), 32'd0);
      chk("rst_cnt",  32'(cnt),  32'd0);
      rst_n = 1'b1;
      repeat (3) step(all_s(0));

      // basic window: 3 hot beats + 4 post beats
      clr();
      step(all_s(500));
      chk("t1_lat_lo", 32'(flag), 32'd0);
      step(all_s(500));
      chk("t1_lat_hi", 32'(flag), 32'd1);
      step(all_s(500));
      repeat (12) step(all_s(100));
      chk("t1_len",  32'(hi_cnt), 32'd7);
      chk("t1_cnt",  32'(cnt),    32'd1);
      chk("t1_done", 32'(flag),   32'd0);

      // time stamp and first index; lane 3 just below HI, lane 5 exactly at HI
      clr();
      ct_v = 16'h1234;
      step(set_lane(set_lane(set_lane(all_s(0), 3, 399), 5, 400), 7, 500));
      repeat (12) step(all_s(100));
      chk("t2_ts",  32'(ts),     32'h1234);
      chk("t2_idx", 32'(fidx),   32'd5);
      chk("t2_len", 32'(hi_cnt), 32'd5);
      chk("t2_cnt", 32'(cnt),    32'd2);

      // retrigger inside post window
      clr();
      ct_v = 16'h0100;
      step(all_s(500));
      step(all_s(100));
      step(all_s(100));
      step(all_s(500));
      repeat (14) step(all_s(100));
      chk("t3_len",   32'(hi_cnt), 32'd8);
      chk("t3_rises", 32'(rises),  32'd1);
      chk("t3_cnt",   32'(cnt),    32'd3);
      chk("t3_ts",    32'(ts),     32'h0100);

      // release needs amp strictly below LO
      clr();
      step(all_s(500));
      repeat (5) step(all_s(200));
      repeat (12) step(all_s(199));
      chk("lo_len", 32'(hi_cnt), 32'd10);
      chk("lo_cnt", 32'(cnt),    32'd4);

      // length cap, holdoff, refire after release
      alen = 8'd10;
      clr();
      repeat (30) step(all_s(500));
      chk("cap_len",   32'(hi_cnt),   32'd10);
      chk("cap_over",  32'(over_cnt), 32'd1);
      chk("cap_rises", 32'(rises),    32'd1);
      chk("cap_cnt",   32'(cnt),      32'd5);
      clr();
      step(all_s(100));
      step(all_s(500));
      repeat (12) step(all_s(100));
      chk("refire_len", 32'(hi_cnt), 32'd5);
      chk("refire_cnt", 32'(cnt),    32'd6);
      alen = 8'd0;

      // negative polarity around baseline 100
      pol = 1'b1; bl = 12'sd100;
      repeat (2) step(all_s(100));
      clr();
      repeat (3) step(all_s(600));
      repeat (3) step(all_s(100));
      chk("neg_no_len", 32'(hi_cnt), 32'd0);
      chk("neg_no_cnt", 32'(cnt),    32'd6);
      clr();
      step(all_s(-400));
      repeat (12) step(all_s(100));
      chk("neg_len", 32'(hi_cnt), 32'd5);
      chk("neg_cnt", 32'(cnt),    32'd7);
      pol = 1'b0; bl = '0;
      repeat (2) step(all_s(100));

      // ENABLE dropped mid-window
      step(all_s(500));
      step(all_s(500));
      chk("en_on", 32'(flag), 32'd1);
      ena = 1'b0;
      step(all_s(500));
      chk("en_drop", 32'(flag), 32'd0);
      repeat (3) step(all_s(500));
      chk("en_idle", 32'(flag), 32'd0);
      step(all_s(100));
      ena = 1'b1;
      repeat (3) step(all_s(100));
      chk("en_cnt_kept", 32'(cnt), 32'd8);

      // asynchronous reset mid-window
      step(all_s(500));
      step(all_s(500));
      chk("rst_mid_on", 32'(flag), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_flag", 32'(flag), 32'd0);
      chk("rst_mid_cnt",  32'(cnt),  32'd0);
      step(all_s(100));
      rst_n = 1'b1;
      plen = 8'd0;

      // back-to-back triggers with no post extension; narrow counter saturates
      repeat (3) step(all_s(100));
      clr();
      for (int i = 0; i < 20; i++) begin
         step(all_s(500));
         step(all_s(100));
      end
      repeat (4) step(all_s(100));
      chk("b2b_cnt",   32'(cnt),    32'd20);
      chk("b2b_rises", 32'(rises),  32'd20);
      chk("b2b_len",   32'(hi_cnt), 32'd20);
      chk("sat_cnt",   32'(s_cnt),  32'hF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
